data_chk: RTL
=============

// Module: data_chk
// PURPOSE
//  Receive-side PRBS checker paired with data_gen. Consumes the 10-bit word stream
//  that data_gen emits (same polynomial, same bit order) and self-synchronises a
//  local LFSR to it. Reports lock, per-word error flag and saturating bit/word counts.
//  Sits at the sink end of the color-filter test datapath for BER measurement.
// PARAMETERS
//  PRBS_LENGTH  20  LFSR order; legal 7,15,20,23,31 (taps x^7+x^6, x^15+x^14, x^20+x^3, x^23+x^18, x^31+x^28, each +1)
//  LOCK_CNT     4   consecutive error-free words in VERIFY needed to declare lock (1..255)
//  LOSS_CNT     4   consecutive errored words in LOCKED that drop lock (1..255)
// PORTS
//  clk           in   1   system clock, all logic on rising edge
//  rst           in   1   asynchronous, active-high reset
//  check_enable  in   1   1 = run checker; 0 = return to IDLE, counters hold
//  clear_cnt     in   1   synchronous clear of err_cnt and word_cnt
//  data_valid    in   1   data_in qualifier; words sampled only when high
//  data_in       in   10  received word; bit 9 = earliest PRBS bit
//  locked        out  1   checker in LOCKED state
//  err_flag      out  1   1-cycle pulse: previous sampled word had >=1 bit error while LOCKED
//  err_cnt       out  32  saturating count of bit errors while LOCKED
//  word_cnt      out  32  saturating count of words checked while LOCKED
// BEHAVIOUR
//  LFSR: state s[N-1:0], N=PRBS_LENGTH, tap T; per bit new=s[N-1]^s[T-1], s<={s[N-2:0],new},
//   emitted bit = new. Ten steps per word, first bit -> data_in[9]. Step combinational, unrolled x10.
//  Reset (async): state IDLE, s=0, locked=0, err_flag=0, err_cnt=0, word_cnt=0, run counters=0.
//  FSM (transitions only on data_valid=1 cycles, except check_enable):
//   IDLE:   check_enable=1 -> SEED (seed bit counter cleared).
//   SEED:   shift received bits into s (10 per word); after ceil(N/10) words -> VERIFY.
//           N=20 -> 2 words; N=31 -> 4 words (s keeps last 31 bits received).
//   VERIFY: predict 10 bits from s, compare to data_in. Match -> good_run+1; s advances.
//           Mismatch -> SEED, with this word as 1st seed word. good_run==LOCK_CNT -> LOCKED.
//           No errors are counted in VERIFY.
//   LOCKED: predict and compare; s advances by predicted bits, never by received bits,
//           so one channel bit error yields exactly one counted error.
//           word_cnt+1 per word. err_cnt += popcount(pred^data_in) (0..10).
//           err_flag=1 next cycle if popcount>0. bad_run+1 on errored word, cleared on clean word.
//           bad_run==LOSS_CNT -> SEED, locked=0; counters keep their values.
//  check_enable=0 in any state -> IDLE next cycle; locked=0, err_flag=0, counters hold.
//  Latency: locked rises 1 cycle after the sampling edge of the LOCK_CNT-th good word.
//   err_flag and counters update 1 cycle after the sampling edge of the word.
//  data_valid=0: no LFSR step, no compare, no counter change, err_flag=0. Gaps are arbitrary.
//  Saturation: err_cnt clamps at 32'hFFFF_FFFF, including when sum would overflow; word_cnt likewise.
//  clear_cnt=1: both counters 0 next cycle, even with a simultaneous valid word; that word's
//   counts are discarded. err_flag and FSM are unaffected.
//  All-zero received seed (s==0): remain in SEED, do not enter VERIFY (lock-up guard).
// TESTING
//  T1 lock: N=20, LOCK_CNT=4; rst 100ns, then check_enable=1 and stream data_gen output ->
//     locked=1 one cycle after 6th valid word; err_cnt=0; word_cnt increments per later word.
//  T2 single error: locked, flip data_in[4] of one word -> err_flag pulses 1 cycle, err_cnt=1,
//     locked stays 1, next clean word -> no further errors (no error multiplication).
//  T3 lock loss: invert all 10 bits of 4 consecutive words -> err_cnt=40, locked=0 after 4th,
//     then relock (locked=1) 6 clean words later.
//  T4 gaps and clear: random data_valid=0 gaps while locked -> err_cnt stays 0; clear_cnt
//     together with a 3-bit-error word -> err_cnt=0, word_cnt=0 next cycle.
//  T5 reset mid-lock: assert rst while locked -> all outputs 0 immediately (async), FSM IDLE.
//  T6 saturation/idle: force err_cnt near 32'hFFFF_FFFA, inject 10-bit error -> 32'hFFFF_FFFF;
//     all-zero input stream -> locked never asserts.

Source files
------------

// File: rtl/data_chk.sv
// Receive-side PRBS checker: self-synchronises a local LFSR to the incoming
// 10-bit word stream and reports lock, per-word error pulse and saturating counts.
module data_chk #(
    parameter int PRBS_LENGTH = 20,
    parameter int LOCK_CNT    = 4,
    parameter int LOSS_CNT    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        check_enable,
    input  logic        clear_cnt,
    input  logic        data_valid,
    input  logic [9:0]  data_in,
    output logic        locked,
    output logic        err_flag,
    output logic [31:0] err_cnt,
    output logic [31:0] word_cnt
);
    localparam int N = PRBS_LENGTH;
    localparam int TAP = (N == 7)  ? 6  :
                         (N == 15) ? 14 :
                         (N == 20) ? 3  :
                         (N == 23) ? 18 : 28;
    localparam int SEED_WORDS = (N + 9) / 10;

    typedef enum logic [1:0] {IDLE, SEED, VERIFY, LOCKED} state_t;

    state_t        state_reg, state_next;
    logic [N-1:0]  s_reg, s_next;
    logic [2:0]    seed_cnt_reg, seed_cnt_next;
    logic [7:0]    good_run_reg, good_run_next;
    logic [7:0]    bad_run_reg, bad_run_next;
    logic          err_flag_reg, err_flag_next;
    logic [31:0]   err_cnt_reg, err_cnt_next;
    logic [31:0]   word_cnt_reg, word_cnt_next;

    logic [N+9:0]  step_out;
    logic [N-1:0]  pred_s;
    logic [9:0]    pred_word;
    logic [N-1:0]  seed_s;
    logic [3:0]    err_bits;
    logic [32:0]   err_sum;
    logic [2:0]    seed_inc;
    logic [7:0]    good_inc;
    logic [7:0]    bad_inc;

    // Ten LFSR steps unrolled; returns {next state, predicted word}, first bit in [9].
    function automatic logic [N+9:0] prbs_step10(input logic [N-1:0] s);
        logic [N-1:0] st;
        logic [9:0]   w;
        logic         nb;
        st = s;
        w  = '0;
        for (int i = 9; i >= 0; i--) begin
            nb   = st[N-1] ^ st[TAP-1];
            w[i] = nb;
            st   = {st[N-2:0], nb};
        end
        return {st, w};
    endfunction

    function automatic logic [3:0] popcount10(input logic [9:0] v);
        logic [3:0] c;
        c = '0;
        for (int i = 0; i < 10; i++) begin
            c = c + {3'd0, v[i]};
        end
        return c;
    endfunction

    assign step_out             = prbs_step10(s_reg);
    assign {pred_s, pred_word}  = step_out;
    assign err_bits             = popcount10(pred_word ^ data_in);
    assign err_sum              = {1'b0, err_cnt_reg} + {29'd0, err_bits};
    assign seed_inc             = seed_cnt_reg + 3'd1;
    assign good_inc             = good_run_reg + 8'd1;
    assign bad_inc              = bad_run_reg + 8'd1;

    // Seeding keeps only the most recent N received bits.
    generate
        if (N > 10) begin : g_seed_wide
            assign seed_s = {s_reg[N-11:0], data_in};
        end else begin : g_seed_narrow
            assign seed_s = data_in[N-1:0];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            s_reg        <= '0;
            seed_cnt_reg <= '0;
            good_run_reg <= '0;
            bad_run_reg  <= '0;
            err_flag_reg <= 1'b0;
            err_cnt_reg  <= '0;
            word_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            s_reg        <= s_next;
            seed_cnt_reg <= seed_cnt_next;
            good_run_reg <= good_run_next;
            bad_run_reg  <= bad_run_next;
            err_flag_reg <= err_flag_next;
            err_cnt_reg  <= err_cnt_next;
            word_cnt_reg <= word_cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        s_next        = s_reg;
        seed_cnt_next = seed_cnt_reg;
        good_run_next = good_run_reg;
        bad_run_next  = bad_run_reg;
        err_flag_next = 1'b0;
        err_cnt_next  = err_cnt_reg;
        word_cnt_next = word_cnt_reg;

        if (!check_enable) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    state_next    = SEED;
                    seed_cnt_next = '0;
                end
                SEED: begin
                    if (data_valid) begin
                        s_next = seed_s;
                        if (seed_inc >= 3'(SEED_WORDS)) begin
                            seed_cnt_next = 3'(SEED_WORDS);
                            // An all-zero seed would lock the LFSR up; keep seeding.
                            if (seed_s != '0) begin
                                state_next    = VERIFY;
                                good_run_next = '0;
                            end
                        end else begin
                            seed_cnt_next = seed_inc;
                        end
                    end
                end
                VERIFY: begin
                    if (data_valid) begin
                        if (pred_word == data_in) begin
                            s_next        = pred_s;
                            good_run_next = good_inc;
                            if (good_inc == 8'(LOCK_CNT)) begin
                                state_next   = LOCKED;
                                bad_run_next = '0;
                            end
                        end else begin
                            state_next    = SEED;
                            s_next        = seed_s;
                            seed_cnt_next = 3'd1;
                        end
                    end
                end
                LOCKED: begin
                    if (data_valid) begin
                        // Free-run on the prediction so channel errors never reach the LFSR.
                        s_next        = pred_s;
                        word_cnt_next = (word_cnt_reg == 32'hFFFF_FFFF) ? word_cnt_reg
                                                                        : word_cnt_reg + 32'd1;
                        err_cnt_next  = err_sum[32] ? 32'hFFFF_FFFF : err_sum[31:0];
                        if (err_bits != 4'd0) begin
                            err_flag_next = 1'b1;
                            if (bad_inc == 8'(LOSS_CNT)) begin
                                state_next    = SEED;
                                seed_cnt_next = '0;
                                bad_run_next  = '0;
                            end else begin
                                bad_run_next = bad_inc;
                            end
                        end else begin
                            bad_run_next = '0;
                        end
                    end
                end
                default: state_next = IDLE;
            endcase
        end

        if (clear_cnt) begin
            err_cnt_next  = '0;
            word_cnt_next = '0;
        end
    end

    assign locked   = (state_reg == LOCKED);
    assign err_flag = err_flag_reg;
    assign err_cnt  = err_cnt_reg;
    assign word_cnt = word_cnt_reg;

endmodule
